// File: rtl/cdp1802_pkg.sv
// rtl/cdp1802_pkg.sv - shared state codes and strobe-phase helpers for the CDP1802 cycle sequencer
package cdp1802_pkg;

  typedef enum logic [1:0] {
    SC_FETCH = 2'b00,
    SC_EXEC  = 2'b01,
    SC_DMA   = 2'b10,
    SC_INT   = 2'b11
  } sc_e;

  localparam logic [3:0] TPA_PHASE = 4'd1;
  localparam logic [3:0] MRD_FIRST = 4'd1;

  function automatic logic [3:0] last_phase(input int cycle_clks);
    return 4'(cycle_clks - 1);
  endfunction

  function automatic logic [3:0] tpb_phase(input int cycle_clks);
    return 4'(cycle_clks - 2);
  endfunction

  function automatic logic [3:0] mwr_first(input int cycle_clks);
    return 4'(cycle_clks - 3);
  endfunction

  function automatic logic [3:0] mwr_last(input int cycle_clks);
    return 4'(cycle_clks - 2);
  endfunction

endpackage

// File: rtl/cdp1802_dma_arb.sv
// rtl/cdp1802_dma_arb.sv - DMA channel grant, round-robin under CDP1802_DMA_ROUND_ROBIN_EN
module cdp1802_dma_arb #(
  parameter int DMA_CH = 2
) (
  input  logic              CLOCK,
  input  logic              CLEAR_N,
  input  logic [DMA_CH-1:0] req,
  input  logic              advance,
  output logic [DMA_CH-1:0] grant
);

  localparam int PW = (DMA_CH > 1) ? $clog2(DMA_CH) : 1;

`ifdef CDP1802_DMA_ROUND_ROBIN_EN
  logic [PW-1:0] last_q;
  logic [PW-1:0] grant_idx;

  // Search starts one past the previous winner and wraps, so every channel gets a turn
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = last_q;
    idx       = 0;
    for (int i = 1; i <= DMA_CH; i++) begin
      idx = int'(last_q) + i;
      if (idx >= DMA_CH) idx = idx - DMA_CH;
      if (grant == '0 && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        grant_idx          = idx[PW-1:0];
      end
    end
  end

  // Remember the winner only when the grant is actually taken at a cycle boundary
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) last_q <= PW'(DMA_CH - 1);
    else if (advance && (|grant)) last_q <= grant_idx;
  end
`else
  // Fixed priority: the lowest requesting index wins
  always_comb begin
    grant = '0;
    for (int i = DMA_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  logic unused_fixed;
  assign unused_fixed = ^{CLOCK, CLEAR_N, advance};
`endif

endmodule

// File: rtl/cdp1802_cycle_seq.sv
// rtl/cdp1802_cycle_seq.sv - CDP1802 machine-cycle sequencer (optional CDP1802_DMA_ROUND_ROBIN_EN)
module cdp1802_cycle_seq
  import cdp1802_pkg::*;
#(
  parameter int                CYCLE_CLKS = 8,
  parameter int                DMA_CH     = 2,
  parameter logic [DMA_CH-1:0] DMA_DIR    = 2'b01,
  parameter int                INT_SRC    = 1,
  localparam int               IW         = (INT_SRC > 1) ? $clog2(INT_SRC) : 1
) (
  input  logic               CLOCK,
  input  logic               CLEAR_N,
  input  logic               WAIT_N,
  input  logic               load_mode,
  input  logic               core_next,
  input  logic               core_rd,
  input  logic               core_wr,
  input  logic               ie_set,
  input  logic               ie_clr,
  input  logic [DMA_CH-1:0]  dma_req,
  input  logic [INT_SRC-1:0] int_req,
  output logic [1:0]         SC,
  output logic [3:0]         phase,
  output logic               cyc_end,
  output logic               init,
  output logic               TPA,
  output logic               TPB,
  output logic               MRD_N,
  output logic               MWR_N,
  output logic [DMA_CH-1:0]  dma_ack,
  output logic               int_ack,
  output logic [IW-1:0]      int_id,
  output logic               IE
);

  sc_e               sc_q, sc_d, sc_arb;
  logic [3:0]        phase_q, phase_d;
  logic              init_q, init_d, idle_q, idle_d, idle_arb;
  logic              ie_q, ie_d, last_next_q, last_next_d, wait_q, wait_d;
  logic [DMA_CH-1:0] dma_ack_q, dma_ack_d, dma_grant;
  logic              int_ack_q, int_ack_d;
  logic [IW-1:0]     int_id_q, int_id_d, low_int;
  logic              real_s1, want_s1, quiet, dma_in, dma_out, rd_cycle, wr_cycle;

  assign cyc_end = !wait_q && (phase_q == last_phase(CYCLE_CLKS));
  assign real_s1 = (sc_q == SC_EXEC) && !init_q && !idle_q;
  assign want_s1 = real_s1 ? core_next : last_next_q;

  cdp1802_dma_arb #(.DMA_CH(DMA_CH)) u_dma_arb (
    .CLOCK   (CLOCK),
    .CLEAR_N (CLEAR_N),
    .req     (dma_req),
    .advance (cyc_end && (sc_arb == SC_DMA)),
    .grant   (dma_grant)
  );

  // Lowest active interrupt source index
  always_comb begin
    low_int = '0;
    for (int i = INT_SRC - 1; i >= 0; i--) begin
      if (int_req[i]) low_int = IW'(i);
    end
  end

  // Cycle-boundary arbitration: which state the next machine cycle runs
  always_comb begin
    sc_arb   = SC_FETCH;
    idle_arb = 1'b0;
    if (load_mode) begin
      sc_arb   = (|dma_req) ? SC_DMA : SC_EXEC;
      idle_arb = !(|dma_req);
    end else if (sc_q == SC_FETCH) sc_arb = SC_EXEC;
    else if (|dma_req)             sc_arb = SC_DMA;
    else if (sc_q == SC_INT)       sc_arb = SC_FETCH;
    else if (ie_q && (|int_req))   sc_arb = SC_INT;
    else if (want_s1)              sc_arb = SC_EXEC;
    else                           sc_arb = SC_FETCH;
  end

  // Next-state: phase count, wait hold, and the commit of arbitration results at cyc_end
  always_comb begin
    phase_d     = phase_q;
    sc_d        = sc_q;
    init_d      = init_q;
    idle_d      = idle_q;
    ie_d        = ie_q;
    last_next_d = last_next_q;
    wait_d      = wait_q;
    dma_ack_d   = dma_ack_q;
    int_ack_d   = int_ack_q;
    int_id_d    = int_id_q;
    if (wait_q) begin
      phase_d = '0;
      wait_d  = !WAIT_N;
    end else if (cyc_end) begin
      phase_d   = '0;
      wait_d    = !WAIT_N;
      sc_d      = sc_arb;
      init_d    = 1'b0;
      idle_d    = idle_arb;
      dma_ack_d = (sc_arb == SC_DMA) ? dma_grant : '0;
      int_ack_d = (sc_arb == SC_INT);
      if (real_s1) last_next_d = core_next;
      if (sc_arb == SC_INT) int_id_d = low_int;
      if (ie_set) ie_d = 1'b1;
      if (ie_clr || (sc_arb == SC_INT)) ie_d = 1'b0;
    end else begin
      phase_d = phase_q + 4'd1;
    end
  end

  // State register; reset lands in the init S1 cycle with strobes idle
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      phase_q     <= '0;
      sc_q        <= SC_EXEC;
      init_q      <= 1'b1;
      idle_q      <= 1'b0;
      ie_q        <= 1'b1;
      last_next_q <= 1'b0;
      wait_q      <= 1'b0;
      dma_ack_q   <= '0;
      int_ack_q   <= 1'b0;
      int_id_q    <= '0;
    end else begin
      phase_q     <= phase_d;
      sc_q        <= sc_d;
      init_q      <= init_d;
      idle_q      <= idle_d;
      ie_q        <= ie_d;
      last_next_q <= last_next_d;
      wait_q      <= wait_d;
      dma_ack_q   <= dma_ack_d;
      int_ack_q   <= int_ack_d;
      int_id_q    <= int_id_d;
    end
  end

  // Strobe decode; read takes precedence so MRD_N and MWR_N never overlap
  assign quiet    = init_q || idle_q || wait_q;
  assign dma_in   = |(dma_ack_q & DMA_DIR);
  assign dma_out  = |(dma_ack_q & ~DMA_DIR);
  assign rd_cycle = (sc_q == SC_FETCH) || ((sc_q == SC_EXEC) && core_rd) ||
                    ((sc_q == SC_DMA) && dma_out);
  assign wr_cycle = ((sc_q == SC_EXEC) && core_wr) || ((sc_q == SC_DMA) && dma_in);

  assign TPA   = !quiet && (phase_q == TPA_PHASE);
  assign TPB   = !quiet && (phase_q == tpb_phase(CYCLE_CLKS));
  assign MRD_N = !(!quiet && rd_cycle && (phase_q >= MRD_FIRST));
  assign MWR_N = !(!quiet && wr_cycle && !rd_cycle &&
                   (phase_q >= mwr_first(CYCLE_CLKS)) && (phase_q <= mwr_last(CYCLE_CLKS)));

  assign SC      = sc_q;
  assign phase   = phase_q;
  assign init    = init_q;
  assign dma_ack = dma_ack_q;
  assign int_ack = int_ack_q;
  assign int_id  = int_id_q;
  assign IE      = ie_q;

endmodule

// File: tb/tb_cdp1802_cycle_seq.sv
// tb/tb_cdp1802_cycle_seq.sv - directed self-checking bench for cdp1802_cycle_seq
module tb_cdp1802_cycle_seq;

  logic       CLOCK = 1'b0;
  logic       CLEAR_N, WAIT_N, load_mode, core_next, core_rd, core_wr, ie_set, ie_clr;
  logic [1:0] dma_req;
  logic [3:0] int_req;
  logic [1:0] SC;
  logic [3:0] phase;
  logic       cyc_end, init, TPA, TPB, MRD_N, MWR_N, int_ack, IE;
  logic [1:0] dma_ack;
  logic [1:0] int_id;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] rr_second;

  cdp1802_cycle_seq #(
    .CYCLE_CLKS (8),
    .DMA_CH     (2),
    .DMA_DIR    (2'b01),
    .INT_SRC    (4)
  ) dut (
    .CLOCK     (CLOCK),
    .CLEAR_N   (CLEAR_N),
    .WAIT_N    (WAIT_N),
    .load_mode (load_mode),
    .core_next (core_next),
    .core_rd   (core_rd),
    .core_wr   (core_wr),
    .ie_set    (ie_set),
    .ie_clr    (ie_clr),
    .dma_req   (dma_req),
    .int_req   (int_req),
    .SC        (SC),
    .phase     (phase),
    .cyc_end   (cyc_end),
    .init      (init),
    .TPA       (TPA),
    .TPB       (TPB),
    .MRD_N     (MRD_N),
    .MWR_N     (MWR_N),
    .dma_ack   (dma_ack),
    .int_ack   (int_ack),
    .int_id    (int_id),
    .IE        (IE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef CDP1802_DMA_ROUND_ROBIN_EN
    rr_second = 2'b10;
`else
    rr_second = 2'b01;
`endif
    CLEAR_N = 1'b0; WAIT_N = 1'b1; load_mode = 1'b0; core_next = 1'b0;
    core_rd = 1'b0; core_wr = 1'b0; ie_set = 1'b0; ie_clr = 1'b0;
    dma_req = 2'b00; int_req = 4'b0000;
    step(2);
    chk("rst_phase", 8'(phase), 8'd0);
    chk("rst_sc", 8'(SC), 8'd1);
    chk("rst_init", 8'(init), 8'd1);
    chk("rst_ie", 8'(IE), 8'd1);
    chk("rst_tpa", 8'(TPA), 8'd0);
    chk("rst_tpb", 8'(TPB), 8'd0);
    chk("rst_mrd", 8'(MRD_N), 8'd1);
    chk("rst_mwr", 8'(MWR_N), 8'd1);
    chk("rst_dma_ack", 8'(dma_ack), 8'd0);
    chk("rst_int_ack", 8'(int_ack), 8'd0);
    chk("rst_int_id", 8'(int_id), 8'd0);
    chk("rst_cyc_end", 8'(cyc_end), 8'd0);

    // init S1 cycle, then S0 / S1 alternation
    CLEAR_N = 1'b1;
    step(1);
    chk("init_p1_phase", 8'(phase), 8'd1);
    chk("init_p1_tpa", 8'(TPA), 8'd0);
    chk("init_p1_mrd", 8'(MRD_N), 8'd1);
    step(6);
    chk("init_p7_cyc_end", 8'(cyc_end), 8'd1);
    step(1);
    chk("s0_sc", 8'(SC), 8'd0);
    chk("s0_init", 8'(init), 8'd0);
    step(1);
    chk("s0_p1_tpa", 8'(TPA), 8'd1);
    chk("s0_p1_mrd", 8'(MRD_N), 8'd0);
    step(5);
    chk("s0_p6_tpb", 8'(TPB), 8'd1);
    chk("s0_p6_mrd", 8'(MRD_N), 8'd0);
    step(1);
    chk("s0_p7_mrd", 8'(MRD_N), 8'd0);
    chk("s0_p7_tpb", 8'(TPB), 8'd0);
    step(1);
    chk("s1_sc", 8'(SC), 8'd1);
    step(1);
    chk("s1_p1_tpa", 8'(TPA), 8'd1);
    chk("s1_p1_mrd", 8'(MRD_N), 8'd1);

    // DMA, both channels requesting
    dma_req = 2'b11;
    step(7);
    chk("dma1_sc", 8'(SC), 8'd2);
    chk("dma1_ack", 8'(dma_ack), 8'd1);
    step(1);
    chk("dma1_p1_mrd", 8'(MRD_N), 8'd1);
    step(4);
    chk("dma1_p5_mwr", 8'(MWR_N), 8'd0);
    step(1);
    chk("dma1_p6_mwr", 8'(MWR_N), 8'd0);
    step(1);
    chk("dma1_p7_mwr", 8'(MWR_N), 8'd1);
    step(1);
    chk("dma2_ack", 8'(dma_ack), 8'(rr_second));
    step(8);
    chk("dma3_sc", 8'(SC), 8'd2);
    chk("dma3_ack", 8'(dma_ack), 8'd1);
    dma_req = 2'b00;

    // Asynchronous clear while MWR_N is low
    step(5);
    chk("dma3_p5_mwr", 8'(MWR_N), 8'd0);
    CLEAR_N = 1'b0;
    #1;
    chk("clr_mwr", 8'(MWR_N), 8'd1);
    chk("clr_sc", 8'(SC), 8'd1);
    chk("clr_phase", 8'(phase), 8'd0);
    chk("clr_dma_ack", 8'(dma_ack), 8'd0);
    CLEAR_N = 1'b1;
    step(1);
    chk("clr_init", 8'(init), 8'd1);
    chk("clr_p1_phase", 8'(phase), 8'd1);

    // Interrupt during S0
    step(7);
    chk("i_s0_sc", 8'(SC), 8'd0);
    int_req = 4'b0100;
    step(8);
    chk("i_s1_sc", 8'(SC), 8'd1);
    chk("i_s1_int_ack", 8'(int_ack), 8'd0);
    step(8);
    chk("i_s3_sc", 8'(SC), 8'd3);
    chk("i_s3_int_ack", 8'(int_ack), 8'd1);
    chk("i_s3_int_id", 8'(int_id), 8'd2);
    chk("i_s3_ie", 8'(IE), 8'd0);
    int_req = 4'b0011;
    step(8);
    chk("i_after_sc", 8'(SC), 8'd0);
    chk("i_after_int_ack", 8'(int_ack), 8'd0);
    step(16);
    chk("i_masked_sc", 8'(SC), 8'd0);
    chk("i_masked_ie", 8'(IE), 8'd0);
    ie_set = 1'b1;
    step(8);
    chk("i_ieset_ie", 8'(IE), 8'd1);
    chk("i_ieset_sc", 8'(SC), 8'd1);
    ie_set = 1'b0;
    step(8);
    chk("i2_sc", 8'(SC), 8'd3);
    chk("i2_int_id", 8'(int_id), 8'd0);
    int_req = 4'b0000;
    step(8);
    chk("i2_after_sc", 8'(SC), 8'd0);

    // WAIT_N held low across an S1 end
    step(8);
    chk("w_s1_sc", 8'(SC), 8'd1);
    WAIT_N = 1'b0;
    step(7);
    chk("w_cyc_end", 8'(cyc_end), 8'd1);
    step(1);
    chk("w_sc", 8'(SC), 8'd0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("w_phase", 8'(phase), 8'd0);
      chk("w_tpa", 8'(TPA), 8'd0);
      chk("w_mrd", 8'(MRD_N), 8'd1);
    end
    WAIT_N = 1'b1;
    step(1);
    chk("w_rel_phase", 8'(phase), 8'd0);
    step(1);
    chk("w_rel_p1_phase", 8'(phase), 8'd1);
    chk("w_rel_p1_mrd", 8'(MRD_N), 8'd0);
    chk("w_rel_sc", 8'(SC), 8'd0);

    // Long instruction: core_next=1 repeats S1, core_rd reads in S1
    step(7);
    core_next = 1'b1;
    core_rd = 1'b1;
    step(1);
    chk("l_p1_mrd", 8'(MRD_N), 8'd0);
    step(7);
    chk("l_s1_again", 8'(SC), 8'd1);
    core_next = 1'b0;
    core_rd = 1'b0;
    step(8);
    chk("l_s0", 8'(SC), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
